// File: rtl/exception_pkg.sv
// Shared types and constants for the exception unit.
// FSM state encoding, cause codes and vector-table byte addresses.
package exception_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OPCODE = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } cause_t;

    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    function automatic logic [31:0] vec_addr(input logic [7:0] v);
        return {24'b0, v};
    endfunction

endpackage

// File: rtl/exception_prio_enc.sv
// Priority encoder: opcode > overflow > div0.
// Ports: exc_*_i request pulses; valid_o any request, cause_o code, vec_o table byte.
module exception_prio_enc
    import exception_pkg::*;
(
    input  logic       exc_opcode_i,
    input  logic       exc_overflow_i,
    input  logic       exc_div0_i,
    output logic       valid_o,
    output cause_t     cause_o,
    output logic [7:0] vec_o
);

    always_comb begin
        valid_o = 1'b1;
        cause_o = CAUSE_NONE;
        vec_o   = 8'd0;
        // Lower-priority requests are simply dropped.
        if (exc_opcode_i) begin
            cause_o = CAUSE_OPCODE;
            vec_o   = VEC_OPCODE;
        end else if (exc_overflow_i) begin
            cause_o = CAUSE_OVF;
            vec_o   = VEC_OVF;
        end else if (exc_div0_i) begin
            cause_o = CAUSE_DIV0;
            vec_o   = VEC_DIV0;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: latches EPC/cause, reads handler byte from vector table.
// Ports: clk, rst_n, pc, exc_* in; mem_rdata in; mem_addr, mem_rd, epc, handler_addr, cause, busy, done out.
module exception_unit
    import exception_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [31:0] handler_addr,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        done
);

    state_t      state_q;
    logic [31:0] epc_q;
    logic [31:0] handler_q;
    cause_t      cause_q;
    logic [31:0] mem_addr_q;
    logic        mem_rd_q;
    logic        busy_q;
    logic        done_q;

    logic        enc_valid;
    cause_t      enc_cause;
    logic [7:0]  enc_vec;

    exception_prio_enc u_enc (
        .exc_opcode_i   (exc_opcode),
        .exc_overflow_i (exc_overflow),
        .exc_div0_i     (exc_div0),
        .valid_o        (enc_valid),
        .cause_o        (enc_cause),
        .vec_o          (enc_vec)
    );

    // Outputs are registered: each is set for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            epc_q      <= 32'd0;
            handler_q  <= 32'd0;
            cause_q    <= CAUSE_NONE;
            mem_addr_q <= 32'd0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (enc_valid) begin
                        state_q    <= ST_REQ;
                        epc_q      <= pc - 32'd4;
                        cause_q    <= enc_cause;
                        mem_addr_q <= vec_addr(enc_vec);
                        mem_rd_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q  <= ST_WAIT1;
                    mem_rd_q <= 1'b0;
                end
                ST_WAIT1: begin
                    state_q <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    // Read data lands two cycles after the strobe.
                    state_q    <= ST_DONE;
                    handler_q  <= {24'b0, mem_rdata};
                    mem_addr_q <= 32'd0;
                    done_q     <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_addr_q <= 32'd0;
                    mem_rd_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign epc          = epc_q;
    assign handler_addr = handler_q;
    assign cause        = cause_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with a 2-cycle-latency vector-table model.
// Ports: none.
module tb_exception_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [7:0]  mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] epc;
    logic [31:0] handler_addr;
    logic [1:0]  cause;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int t1;
    int n0;

    exception_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .epc          (epc),
        .handler_addr (handler_addr),
        .cause        (cause),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector-table memory: data valid exactly two cycles after mem_rd.
    logic        rd_d1, rd_d2;
    logic [31:0] a_d1, a_d2;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'd253: return 8'h40;
            32'd254: return 8'h7C;
            32'd255: return 8'hA8;
            default: return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_d1 <= mem_rd;
        a_d1  <= mem_addr;
        rd_d2 <= rd_d1;
        a_d2  <= a_d1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign mem_rdata = rd_d2 ? rom(a_d2) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_exc();
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        exc_div0     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pc    = 32'd0;
        rd_d1 = 1'b0;
        rd_d2 = 1'b0;
        a_d1  = 32'd0;
        a_d2  = 32'd0;
        clr_exc();
        tick();
        tick();
        chk("rst_epc", epc, 32'd0);
        chk("rst_hdl", handler_addr, 32'd0);
        chk("rst_cause", {30'd0, cause}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ctl", {29'd0, mem_rd, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_no_rd", {31'd0, mem_rd}, 32'd0);

        // Overflow at pc 0x104
        pc = 32'h104;
        exc_overflow = 1'b1;
        tick();
        clr_exc();
        chk("ovf_rd", {31'd0, mem_rd}, 32'd1);
        chk("ovf_addr", mem_addr, 32'd254);
        chk("ovf_epc", epc, 32'h100);
        chk("ovf_cause", {30'd0, cause}, 32'd2);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("w1_rd", {31'd0, mem_rd}, 32'd0);
        chk("w1_addr", mem_addr, 32'd254);
        tick();
        chk("w2_addr", mem_addr, 32'd254);
        chk("w2_done", {31'd0, done}, 32'd0);
        tick();
        chk("ovf_done", {31'd0, done}, 32'd1);
        chk("ovf_hdl", handler_addr, 32'h7C);
        chk("done_addr", mem_addr, 32'd0);
        tick();
        chk("idle_ctl", {30'd0, busy, done}, 32'd0);
        chk("hold_hdl", handler_addr, 32'h7C);
        chk("hold_epc", epc, 32'h100);
        chk("hold_cause", {30'd0, cause}, 32'd2);

        // opcode + div0 together
        pc = 32'h20;
        exc_opcode = 1'b1;
        exc_div0   = 1'b1;
        tick();
        clr_exc();
        chk("pri_addr", mem_addr, 32'd253);
        chk("pri_cause", {30'd0, cause}, 32'd1);
        chk("pri_epc", epc, 32'h1C);
        tick();
        tick();
        tick();
        chk("pri_done", {31'd0, done}, 32'd1);
        chk("pri_hdl", handler_addr, 32'h40);
        tick();

        // div0 at pc 0: wrap-around
        pc = 32'h0;
        exc_div0 = 1'b1;
        tick();
        clr_exc();
        chk("wrap_epc", epc, 32'hFFFF_FFFC);
        chk("wrap_addr", mem_addr, 32'd255);
        chk("wrap_cause", {30'd0, cause}, 32'd3);
        tick();
        tick();
        tick();
        chk("wrap_hdl", handler_addr, 32'hA8);
        tick();

        // overflow during WAIT1 is ignored
        n0 = done_cnt;
        pc = 32'h50;
        exc_opcode = 1'b1;
        tick();
        clr_exc();
        tick();
        pc = 32'h999;
        exc_overflow = 1'b1;
        tick();
        clr_exc();
        chk("ign_cause", {30'd0, cause}, 32'd1);
        chk("ign_epc", epc, 32'h4C);
        chk("ign_addr", mem_addr, 32'd253);
        tick();
        tick();
        tick();
        tick();
        chk("ign_rd", {31'd0, mem_rd}, 32'd0);
        chk("ign_ndone", done_cnt - n0, 32'd1);
        chk("ign_cause2", {30'd0, cause}, 32'd1);

        // reset during WAIT2
        n0 = done_cnt;
        pc = 32'h60;
        exc_opcode = 1'b1;
        tick();
        clr_exc();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_epc", epc, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_ctl", {27'd0, cause, mem_rd, busy, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_ndone", done_cnt - n0, 32'd0);
        chk("arst_no_rd", {31'd0, mem_rd}, 32'd0);
        pc = 32'h64;
        exc_opcode = 1'b1;
        tick();
        clr_exc();
        chk("post_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        tick();
        chk("post_d3", {31'd0, done}, 32'd0);
        tick();
        chk("post_done", {31'd0, done}, 32'd1);
        chk("post_epc", epc, 32'h60);
        chk("post_hdl", handler_addr, 32'h40);
        tick();

        // back-to-back sequences
        pc = 32'h200;
        exc_overflow = 1'b1;
        tick();
        clr_exc();
        tick();
        tick();
        tick();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        t1 = cyc;
        tick();
        pc = 32'h300;
        exc_overflow = 1'b1;
        tick();
        clr_exc();
        chk("b2b_epc", epc, 32'h2FC);
        chk("b2b_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        tick();
        chk("b2b_nd", {31'd0, done}, 32'd0);
        tick();
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_gap", cyc - t1, 32'd5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
